// File: rtl/psmac_job_ctrl.sv
// Job sequencer for the precision-scalable OAFU MAC: streams operand beats into OAFU,
// drives mode/sign-mask controls and accumulates the registered OAFU result.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | accepting operand beats
//   DRAIN | waiting for in-flight OAFU results
//   HOLD  | result presented until consumed
module psmac_job_ctrl #(
  parameter int          LEN_W   = 16,
  parameter int          ACC_W   = 32,
  parameter logic [15:0] MASK_2B = 16'hFFFF,
  parameter logic [15:0] MASK_4B = 16'hAAAA,
  parameter logic [15:0] MASK_8B = 16'h8888
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_prec,
  input  logic             i_sgn_x,
  input  logic             i_sgn_y,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_op_valid,
  output logic             o_op_ready,
  input  logic [31:0]      i_ip_in,
  input  logic [31:0]      i_wt_in,
  output logic [31:0]      o_oafu_ip,
  output logic [31:0]      o_oafu_wt,
  output logic [15:0]      o_oafu_sx,
  output logic [15:0]      o_oafu_sy,
  output logic             o_oafu_mode1,
  output logic             o_oafu_mode2,
  input  logic [15:0]      i_oafu_y,
  output logic             o_busy,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_acc_valid,
  input  logic             i_acc_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_issued;
  logic             r_v1;
  logic             r_v2;
  logic [ACC_W-1:0] r_acc;
  logic             w_beat;
  logic             w_last_beat;
  logic             w_start_ok;
  logic [15:0]      w_mask;
  logic [ACC_W-1:0] w_y_ext;

  assign o_op_ready  = (r_state == S_RUN) && (r_issued < r_len);
  assign w_beat      = i_op_valid && o_op_ready;
  assign w_last_beat = w_beat && ((r_issued + LEN_W'(1)) == r_len);
  assign w_start_ok  = (r_state == S_IDLE) && i_start;
  assign w_y_ext     = {{(ACC_W-16){i_oafu_y[15]}}, i_oafu_y};
  assign o_busy      = (r_state != S_IDLE);
  assign o_acc_valid = (r_state == S_HOLD);
  assign o_acc       = r_acc;

  always_comb begin
    w_mask = MASK_8B;
    case (i_prec)
      2'b00:   w_mask = MASK_2B;
      2'b01:   w_mask = MASK_4B;
      default: w_mask = MASK_8B;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_len != '0) ? S_RUN : S_HOLD;
      S_RUN:   if (w_last_beat) w_state_nxt = S_DRAIN;
      // v1 clear means the final result sits in v2 and is added this cycle
      S_DRAIN: if (!r_v1) w_state_nxt = S_HOLD;
      S_HOLD:  if (i_acc_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_issued     <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_acc        <= '0;
      o_oafu_ip    <= '0;
      o_oafu_wt    <= '0;
      o_oafu_sx    <= '0;
      o_oafu_sy    <= '0;
      o_oafu_mode1 <= 1'b0;
      o_oafu_mode2 <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_v1      <= w_beat;
      r_v2      <= r_v1;
      o_oafu_ip <= w_beat ? i_ip_in : '0;
      o_oafu_wt <= w_beat ? i_wt_in : '0;
      if (w_beat) r_issued <= r_issued + LEN_W'(1);
      if (r_v2) r_acc <= r_acc + w_y_ext;
      if (w_start_ok) begin
        r_len        <= i_len;
        r_issued     <= '0;
        r_acc        <= '0;
        o_oafu_mode1 <= |i_prec;
        o_oafu_mode2 <= i_prec[1];
        o_oafu_sx    <= i_sgn_x ? w_mask : '0;
        o_oafu_sy    <= i_sgn_y ? w_mask : '0;
      end
    end
  end

endmodule

// File: tb/tb_psmac_job_ctrl.sv
// Scoreboard bench for psmac_job_ctrl with a registered OAFU stub whose result
// is y_const for an operand beat and idle_y for all-zero operands.
module tb_psmac_job_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  prec;
  logic        sgn_x, sgn_y;
  logic [15:0] len;
  logic        op_valid, op_ready;
  logic [31:0] ip_in, wt_in, oafu_ip, oafu_wt;
  logic [15:0] oafu_sx, oafu_sy, stub_y;
  logic        mode1, mode2, busy, acc_valid, acc_ready;
  logic [31:0] acc;
  logic [15:0] y_const, idle_y;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  psmac_job_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_prec(prec),
    .i_sgn_x(sgn_x), .i_sgn_y(sgn_y), .i_len(len),
    .i_op_valid(op_valid), .o_op_ready(op_ready),
    .i_ip_in(ip_in), .i_wt_in(wt_in),
    .o_oafu_ip(oafu_ip), .o_oafu_wt(oafu_wt),
    .o_oafu_sx(oafu_sx), .o_oafu_sy(oafu_sy),
    .o_oafu_mode1(mode1), .o_oafu_mode2(mode2),
    .i_oafu_y(stub_y), .o_busy(busy), .o_acc(acc),
    .o_acc_valid(acc_valid), .i_acc_ready(acc_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) stub_y <= (oafu_ip == 32'h0 && oafu_wt == 32'h0) ? idle_y : y_const;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // result monitor: pops one expected value per completed output handshake
  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none", acc);
      end else begin
        check("acc_result", acc, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] p, input logic sx, input logic sy, input logic [15:0] l);
    start = 1'b1; prec = p; sgn_x = sx; sgn_y = sy; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [31:0] ip, input logic [31:0] wt, input bit gap);
    int sent = 0;
    int guard = 0;
    ip_in = ip; wt_in = wt;
    while (sent < n && guard < 200) begin
      op_valid = gap ? ((guard % 2) == 0) : 1'b1;
      if (op_valid && op_ready) sent++;
      tick();
      guard++;
    end
    op_valid = 1'b0;
    check("beats_accepted", sent, n);
  endtask

  task automatic wait_hold(output int c);
    int g = 0;
    while (!acc_valid && g < 100) begin
      tick();
      g++;
    end
    check("hold_reached", {31'b0, acc_valid}, 32'd1);
    c = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, c;
    rst = 1'b1; start = 1'b0; prec = 2'b00; sgn_x = 1'b0; sgn_y = 1'b0; len = 16'd0;
    op_valid = 1'b0; ip_in = 32'h0; wt_in = 32'h0; acc_ready = 1'b1;
    y_const = 16'd16; idle_y = 16'd1000;
    tick(); tick();
    check("reset_ctrl", {27'b0, busy, op_ready, acc_valid, mode1, mode2}, 32'h0);
    check("reset_acc", acc, 32'h0);
    rst = 1'b0;
    tick();

    // 2b unsigned, three back-to-back beats
    exp_q.push_back(32'd48);
    start_job(2'b00, 1'b0, 1'b0, 16'd3);
    check("t1_mode", {30'b0, mode1, mode2}, 32'h0);
    check("t1_masks", {oafu_sx, oafu_sy}, 32'h0);
    check("t1_busy_ready", {30'b0, busy, op_ready}, 32'h3);
    t0 = cyc;
    send_beats(3, 32'h55555555, 32'h55555555, 1'b0);
    check("t1_oafu_ip_last", oafu_ip, 32'h55555555);
    tick();
    check("t1_oafu_ip_idle", oafu_ip, 32'h0);
    wait_hold(c);
    check("t1_hold_latency", c - t0, 32'd5);
    tick();
    check("t1_back_idle", {30'b0, busy, acc_valid}, 32'h0);

    // 2b signed
    exp_q.push_back(32'd32);
    start_job(2'b00, 1'b1, 1'b1, 16'd2);
    check("t2_masks", {oafu_sx, oafu_sy}, 32'hFFFFFFFF);
    send_beats(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    wait_hold(c);
    tick();

    // operand valid in IDLE is ignored
    op_valid = 1'b1; ip_in = 32'h12345678; wt_in = 32'h9ABCDEF0;
    check("idle_op_ready", {31'b0, op_ready}, 32'h0);
    tick();
    op_valid = 1'b0;
    check("idle_oafu_ip", oafu_ip, 32'h0);

    // 8b signed, stub y = -5, gapped beats
    y_const = 16'hFFFB;
    exp_q.push_back(32'hFFFFFFEC);
    start_job(2'b10, 1'b1, 1'b1, 16'd4);
    check("t3_mode", {30'b0, mode1, mode2}, 32'h3);
    check("t3_masks", {oafu_sx, oafu_sy}, 32'h88888888);
    send_beats(4, 32'hA5A5A5A5, 32'h3C3C3C3C, 1'b1);
    wait_hold(c);
    tick();

    // len = 0, 4b, x signed
    exp_q.push_back(32'h0);
    start_job(2'b01, 1'b1, 1'b0, 16'd0);
    check("t4_valid_ready", {30'b0, acc_valid, op_ready}, 32'h2);
    check("t4_mode", {30'b0, mode1, mode2}, 32'h2);
    check("t4_masks", {oafu_sx, oafu_sy}, 32'hAAAA0000);
    check("t4_acc", acc, 32'h0);
    tick();
    check("t4_idle", {31'b0, busy}, 32'h0);

    // backpressure in HOLD, prec=11 behaves as 8b
    acc_ready = 1'b0;
    y_const = 16'd7;
    exp_q.push_back(32'd7);
    start_job(2'b11, 1'b0, 1'b0, 16'd1);
    check("t5_mode", {30'b0, mode1, mode2}, 32'h3);
    send_beats(1, 32'h00000101, 32'h00000202, 1'b0);
    wait_hold(c);
    for (int i = 0; i < 10; i++) begin
      start = (i == 3); len = 16'd0;
      check("t5_acc_stable", acc, 32'd7);
      check("t5_busy_valid", {30'b0, busy, acc_valid}, 32'h3);
      tick();
    end
    acc_ready = 1'b1; start = 1'b1; len = 16'd2;
    tick();
    start = 1'b0;
    check("t5_handshake_start_ignored", {29'b0, busy, acc_valid, op_ready}, 32'h0);
    tick();

    // async reset mid-RUN, aborted job produces no result
    y_const = 16'd3;
    start_job(2'b10, 1'b1, 1'b1, 16'd5);
    send_beats(2, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    tick();
    check("t6_partial_acc", acc, 32'd3);
    rst = 1'b1;
    #1;
    check("t6_reset_ctrl", {27'b0, busy, op_ready, acc_valid, mode1, mode2}, 32'h0);
    check("t6_reset_acc", acc, 32'h0);
    check("t6_reset_masks", {oafu_sx, oafu_sy}, 32'h0);
    check("t6_reset_ip", oafu_ip | oafu_wt, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    y_const = 16'd9;
    exp_q.push_back(32'd9);
    start_job(2'b00, 1'b0, 1'b0, 16'd1);
    send_beats(1, 32'h00000001, 32'h00000001, 1'b0);
    wait_hold(c);
    tick(); tick();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
